// File: rtl/cdc_pkg.sv
// Shared types and default constants for the 4-phase CDC handshake blocks.
// Used by the transmitter here and by the matching receiver.
package cdc_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT     = 1023;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK,
    WAIT_NACK
  } tx_state_t;

endpackage

// File: rtl/sync_nff.sv
// N-flop single-bit synchronizer with asynchronous active-low reset to 0.
// Generic so the receiver side can reuse it for the request line.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack CDC handshake: registers the payload, raises
// the request one cycle later, and waits for the synchronized acknowledge to rise and fall.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] xfer_data_o,
  output logic              xfer_req_o,
  input  logic              xfer_ack_i,
  output logic              busy_o,
  output logic              timeout_o,
  input  logic              timeout_clr_i
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  tx_state_t        state_q, state_d;
  logic             ack_s;
  logic             req_d;
  logic             load;
  logic             waiting;
  logic             timeout_set;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d       (xfer_ack_i),
    .q       (ack_s)
  );

  // A stale acknowledge from a previous handshake must drain before a new accept.
  assign ready_o = (state_q == IDLE) && !ack_s;
  assign busy_o  = (state_q != IDLE);
  assign waiting = (state_q == WAIT_ACK) || (state_q == WAIT_NACK);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    req_d   = xfer_req_o;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_NACK;
        end
      end
      WAIT_NACK: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // The timeout only flags a slow receiver; the handshake itself is never abandoned.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    timeout_set = waiting && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      xfer_req_o  <= 1'b0;
      xfer_data_o <= '0;
      cnt_q       <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      xfer_req_o <= req_d;
      cnt_q      <= cnt_d;
      if (load) begin
        xfer_data_o <= data_i;
      end
      // Set has priority so a clear racing the timeout cannot hide it.
      if (timeout_set) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

endmodule
